// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot-load sequencer.
package boot_pkg;

  // Top-level sequencer states.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } boot_state_e;

  // Byte receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Bit positions inside err_o.
  localparam int ERR_FRAME = 0;
  localparam int ERR_OVF   = 1;

  // Image terminator; never written to instruction memory.
  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit start re-check,
// centre sampling of data and stop bits. Outputs are one-cycle pulses.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       rx_i,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchronise rx and keep the previous synchronised value for edge detect.
  // These idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timer and frame sequencing; tmr counts down to the next bit centre.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          tmr_d   = TMR_HALF;
        end
      end
      RX_START: begin
        if (tmr_q == '0) begin
          if (!rx_s2_q) begin
            state_d = RX_DATA;
            tmr_d   = TMR_FULL;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;  // glitch, not a real start bit
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RX_DATA: begin
        if (tmr_q == '0) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          tmr_d   = TMR_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RX_STOP: begin
        if (tmr_q == '0) begin
          state_d = RX_IDLE;
          if (rx_s2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: assembles little-endian words from UART bytes, writes
// them to instruction memory over req/gnt, and releases the core on END_WORD.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] END_WORD     = END_WORD_DEFAULT,
  parameter int          START_DLY    = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_i,
  output logic              prog_ready_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_l_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  localparam int DLY_W = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(START_DLY - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic       rx_valid, frame_err;
  logic [7:0] rx_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst_l    (rst_l),
    .rx_i     (rx_i),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  boot_state_e       state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;   // last address already written
  logic              skid_v_q, skid_v_d;
  logic [7:0]        skid_q, skid_d;
  logic [1:0]        err_q, err_d;
  logic              ready_q, done_q, core_q;

  logic              byte_take;
  logic [7:0]        byte_val;
  logic [31:0]       word_nx;

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= ST_WAIT;
      dly_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      full_q   <= 1'b0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      full_q   <= full_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      err_q    <= err_d;
    end
  end

  // Status outputs follow the state by one cycle. Ready stays high in WRITE
  // because the skid register still accepts a byte there.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      core_q  <= 1'b0;
    end else begin
      ready_q <= (state_q == ST_RECV) || (state_q == ST_WRITE);
      done_q  <= (state_q == ST_DONE);
      core_q  <= (state_q == ST_DONE);
    end
  end

  // Next-state: start delay, byte assembly, write handshake, skid, errors.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    addr_d    = addr_q;
    full_d    = full_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    err_d     = err_q;
    byte_take = 1'b0;
    byte_val  = rx_data;
    word_nx   = word_q;

    if (frame_err) err_d[ERR_FRAME] = 1'b1;

    case (state_q)
      ST_WAIT: begin
        dly_d = dly_q + DLY_W'(1);
        if (dly_q == DLY_LAST) state_d = ST_RECV;
      end
      ST_RECV: begin
        // A buffered byte is older than anything arriving now.
        if (skid_v_q) begin
          byte_take = 1'b1;
          byte_val  = skid_q;
          skid_v_d  = rx_valid;
          skid_d    = rx_valid ? rx_data : skid_q;
        end else if (rx_valid) begin
          byte_take = 1'b1;
          byte_val  = rx_data;
        end
        if (byte_take) begin
          word_nx[{cnt_q, 3'b000} +: 8] = byte_val;
          word_d = word_nx;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (word_nx == END_WORD) state_d = ST_DONE;
            else if (full_q)         err_d[ERR_OVF] = 1'b1;
            else                     state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (rx_valid) begin
          if (skid_v_q) begin
            err_d[ERR_OVF] = 1'b1;
          end else begin
            skid_v_d = 1'b1;
            skid_d   = rx_data;
          end
        end
        if (mem_gnt_i) begin
          state_d = ST_RECV;
          if (addr_q == ADDR_MAX) full_d = 1'b1;
          else                    addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_WAIT;
    endcase
  end

  assign prog_ready_o = ready_q;
  assign mem_req_o    = (state_q == ST_WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = word_q;
  assign core_rst_l_o = core_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl with a write scoreboard.
module tb_uart_boot_ctrl;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int SD    = 16;
  localparam int EXP_W = AW + 32;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          rx_i;
  logic          mem_gnt_i;
  logic          prog_ready_o, mem_req_o, core_rst_l_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [1:0]    err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [AW-1:0]    exp_addr;

  logic          stall_q = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_data;

  uart_boot_ctrl #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .START_DLY   (SD)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .rx_i        (rx_i),
    .prog_ready_o(prog_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .core_rst_l_o(core_rst_l_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i = stop_bit;
    repeat (CPB) tick();
    rx_i = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_write);
    if (expect_write) begin
      exp_q.push_back({exp_addr, w});
      exp_addr = exp_addr + 1'b1;
    end
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mem_req_o) && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_req_idle"}, mem_req_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prog_ready"}, prog_ready_o, 0);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_core_rst_l"}, core_rst_l_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  // Write monitor: pops the scoreboard on each accepted request and checks
  // that a stalled request holds address and data.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_l === 1'b1) begin
      if (stall_q) begin
        check("stall_req_held", mem_req_o, 1);
        check("stall_addr_stable", mem_addr_o, hold_addr);
        check("stall_data_stable", mem_wdata_o, hold_data);
      end
      if (mem_req_o && mem_gnt_i) begin
        stall_q = 1'b0;
        check("write_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e[EXP_W-1:32]);
          check("wr_data", mem_wdata_o, e[31:0]);
        end
      end else if (mem_req_o) begin
        stall_q   = 1'b1;
        hold_addr = mem_addr_o;
        hold_data = mem_wdata_o;
      end else begin
        stall_q = 1'b0;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [31:0] w;
    rst_l     = 1'b0;
    rx_i      = 1'b1;
    mem_gnt_i = 1'b1;
    exp_addr  = '0;
    repeat (3) tick();
    check_all_zero("por");

    // Start delay: ready rises on the 17th edge after release.
    rst_l = 1'b1;
    for (int i = 1; i <= SD; i++) begin
      tick();
      check("ready_during_wait", prog_ready_o, 0);
      check("req_during_wait", mem_req_o, 0);
      check("core_rst_during_wait", core_rst_l_o, 0);
    end
    tick();
    check("ready_after_dly", prog_ready_o, 1);

    // Two words with grant tied high.
    send_word(32'h1234_5678, 1);
    send_word(32'hDEAD_BEEF, 1);
    drain("basic");
    check("basic_err", err_o, 2'b00);
    check("basic_next_addr", mem_addr_o, 2);
    check("basic_core_rst", core_rst_l_o, 0);

    // Framing error: byte dropped, next four bytes form the word.
    send_byte(8'hA5, 1'b0);
    check("frame_err_set", err_o, 2'b01);
    send_word(32'hA1B2_C3D4, 1);
    drain("after_frame");

    // Grant stall with one buffered byte and one overrun.
    mem_gnt_i = 1'b0;
    send_word(32'hCAFE_F00D, 1);
    check("stall_req_up", mem_req_o, 1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("stall_req_still", mem_req_o, 1);
    check("stall_addr", mem_addr_o, 3);
    check("overrun_err", err_o, 2'b11);
    exp_q.push_back({exp_addr, 32'h5544_3311});
    exp_addr = exp_addr + 1'b1;
    mem_gnt_i = 1'b1;
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    drain("after_stall");
    check("stall_core_rst", core_rst_l_o, 0);
    check("stall_done", done_o, 0);

    // Reset in the middle of a word.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rst_l = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (3) tick();
    rst_l    = 1'b1;
    exp_addr = '0;
    repeat (SD + 2) tick();
    check("ready_after_rerelease", prog_ready_o, 1);
    send_word(32'h4433_2211, 1);
    drain("post_reset");
    check("post_reset_err", err_o, 2'b00);

    // Fill the remaining addresses up to the last one.
    for (int a = 1; a < (1 << AW); a++) begin
      w = $urandom();
      if (w == 32'h0000_0FFF) w = w ^ 32'h1;
      send_word(w, 1);
    end
    drain("fill");
    check("fill_err", err_o, 2'b00);
    check("fill_addr_at_max", mem_addr_o, 4'hF);

    // One word past the end: no write, overflow flag, no wrap.
    send_word(32'h1357_2468, 0);
    drain("overflow");
    check("overflow_err", err_o, 2'b10);
    check("overflow_addr_no_wrap", mem_addr_o, 4'hF);
    check("overflow_core_rst", core_rst_l_o, 0);

    // Terminator: no write, core released, later bytes ignored.
    send_word(32'h0000_0FFF, 0);
    check("end_done", done_o, 1);
    check("end_core_rst", core_rst_l_o, 1);
    check("end_ready", prog_ready_o, 0);
    check("end_req", mem_req_o, 0);
    send_word(32'h0102_0304, 0);
    drain("after_end");
    check("end_done_sticky", done_o, 1);
    check("end_err", err_o, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_ctrl.md
Name: uart_boot_ctrl

Overview:
Boot-load sequencer for the BrqRV_EB1 user project. It receives the program image serially on the UART RX pin, sourced off-chip by the programmer on mprj_io[5]. It assembles little-endian 32-bit words and writes them sequentially into instruction memory through a req/gnt port. It holds the core in reset until an end-of-image word arrives, then releases the core. It also drives the "ready to receive" indication that is exported on mprj_io[37].

Parameters:
CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200 baud); minimum 4.
ADDR_W, 12, instruction-memory word-address width.
END_WORD, 32'h0000_0FFF, terminator word; it is never written to memory.
START_DLY, 16, cycles from reset release to prog_ready_o assertion.

Ports:
clk  in  1  system clock
rst_l  in  1  reset, asynchronous, active-low
rx_i  in  1  UART serial input, 8N1, idle high; asynchronous to clk
prog_ready_o  out  1  high while accepting image bytes
mem_req_o  out  1  instruction-memory write request
mem_gnt_i  in  1  write accepted this cycle
mem_addr_o  out  ADDR_W  word address
mem_wdata_o  out  32  write data
core_rst_l_o  out  1  core reset, active-low; 0 until image loaded
done_o  out  1  image load complete (sticky)
err_o  out  2  sticky errors: [0] framing, [1] overrun or address overflow

Behaviour:
- Reset (async assert, synchronous release via rst_l): every output = 0 (core_rst_l_o = 0 holds the core in reset). Counters, byte count, skid buffer and error flags all clear. A partial word is discarded.
- rx_i passes through a 2-flop synchroniser.
- The receiver arms on a falling edge. The start bit is re-checked at mid-bit; if rx is high, it is treated as a glitch and the receiver returns to idle.
- Data bits are sampled at bit centres, LSB first. The stop bit is sampled at centre:
  - stop = 1: one-cycle rx_valid pulse with the byte.
  - stop = 0: err_o[0] is set and the byte is dropped.
- FSM states and transitions:
  - WAIT: count START_DLY cycles, then go to RECV.
  - RECV: prog_ready_o = 1. Each valid byte goes into word[8*cnt +: 8]; cnt goes 0..3. When the 4th byte lands:
    - word == END_WORD: go to DONE, no write.
    - otherwise: go to WRITE.
  - WRITE: mem_req_o = 1. mem_addr_o and mem_wdata_o are held stable until the cycle in which mem_gnt_i = 1. In that cycle, addr += 1 and the FSM returns to RECV (mem_req_o drops the next cycle). Minimum spacing between requests is therefore 2 cycles.
  - DONE: done_o = 1, core_rst_l_o = 1 and prog_ready_o = 0, all registered one cycle after entry. Later bytes are ignored. DONE is left only by reset.
- Stall buffering: a byte completing while in WRITE is held in a 1-entry skid register and consumed on return to RECV. A second byte arriving while the skid register is full sets err_o[1] and is dropped.
- Address wrap: a write to address 2^ADDR_W-1 is permitted. A later non-END word sets err_o[1], is not written, and addr does not wrap.
- An END_WORD sitting in the skid path is treated exactly as if it had arrived in RECV.
- Error flags never block progress; they are cleared only by reset.

Decomposition:
- Shared package boot_pkg holds:
  - FSM state enum (WAIT, RECV, WRITE, DONE)
  - error bit indices ERR_FRAME = 0, ERR_OVF = 1
  - default END_WORD
- Sub-module uart_rx_byte (params CLKS_PER_BIT):
  - inputs clk, rst_l, rx_i
  - outputs rx_valid, rx_data[7:0], frame_err
  - contains the synchroniser and bit timer.

Test Plan:
(Bench parameters: CLKS_PER_BIT = 4, ADDR_W = 4, START_DLY = 16.)
1. Release rst_l -> prog_ready_o rises exactly 16 cycles later (+1 registered). core_rst_l_o = 0, mem_req_o = 0 throughout.
2. Send 78 56 34 12, then EF BE AD DE, with mem_gnt_i tied 1:
   - writes addr 0 / 32'h12345678, then addr 1 / 32'hDEADBEEF
   - one req cycle each; err_o = 0.
3. Hold mem_gnt_i = 0 for 80 cycles after the first word, while 2 more bytes arrive:
   - req, addr and data stay stable during the stall.
   - err_o[1] = 1 because the second byte overruns the skid register.
   - after gnt, the next word contains the first buffered byte in [7:0].
4. Send FF 0F 00 00 -> no mem_req_o. done_o = 1 and core_rst_l_o = 1 next cycle, prog_ready_o = 0. Subsequent bytes cause no writes.
5. Byte 0xA5 with stop bit 0 -> err_o[0] = 1, byte dropped. The following 4 good bytes form the word at the current address.
6. Assert rst_l after 2 bytes of a word -> all outputs 0 immediately. After release and START_DLY, 11 22 33 44 writes addr 0 / 32'h44332211.
